// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM controller.
//   - SDRAM command encodings as {cs_n, ras_n, cas_n, we_n}
//   - bank / address / data / command widths
//   - arbiter state type
package sdram_pkg;

  localparam int CMD_W  = 4;
  localparam int BA_W   = 2;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  localparam logic [CMD_W-1:0] SDRAM_CMD_NOP         = 4'b0111;
  localparam logic [CMD_W-1:0] SDRAM_CMD_PRECHARGE   = 4'b0010;
  localparam logic [CMD_W-1:0] SDRAM_CMD_AUTOREFRESH = 4'b0001;
  localparam logic [CMD_W-1:0] SDRAM_CMD_ACTIVE      = 4'b0011;
  localparam logic [CMD_W-1:0] SDRAM_CMD_READ        = 4'b0101;
  localparam logic [CMD_W-1:0] SDRAM_CMD_WRITE       = 4'b0100;

  // Idle bus values driven while the arbiter is choosing an engine.
  localparam logic [BA_W-1:0]   IDLE_BA   = 2'b11;
  localparam logic [ADDR_W-1:0] IDLE_ADDR = 12'hFFF;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/sdram_arbit.sv
// sdram_arbit: central arbiter and command multiplexer of the SDRAM controller.
//
// Grants one of the refresh / write / read engines at a time (fixed priority
// refresh > write > read) after initialisation completes, and routes the
// granted engine's command, bank and address onto the SDRAM pins.
//
// Ports:
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   init_done, init_*           init engine handshake and bus
//   ar_req/ar_end, ar_*         refresh engine handshake and bus
//   wr_req/wr_end, wr_*         write engine handshake and bus
//   wr_sdram_en, wr_sdram_data  write data strobe and data
//   rd_req/rd_end, rd_*         read engine handshake and bus
//   ar_en, wr_en, rd_en         one-cycle grant pulses
//   sdram_*                     SDRAM command/address/data pins
//   arb_err                     sticky grant-timeout flag
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter logic [9:0]       TIMEOUT_MAX = 10'd1000,
  parameter logic [CMD_W-1:0] CMD_NOP     = 4'b0111
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_done,
  input  logic [CMD_W-1:0]  init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              ar_req,
  input  logic              ar_end,
  input  logic [CMD_W-1:0]  ar_cmd,
  input  logic [BA_W-1:0]   ar_ba,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [CMD_W-1:0]  wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [CMD_W-1:0]  rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              ar_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_o,
  output logic              sdram_dq_oe,
  output logic              arb_err
);

  arb_state_t  state_q, state_d;
  logic        ar_en_q, ar_en_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic        err_q, err_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        grant_end;

  // Next-state / grant / timeout logic. Grant pulses are produced on the
  // ARBIT -> granted transition only, so they are high for exactly the first
  // cycle of the grant and cannot re-fire on the engine's end cycle.
  always_comb begin
    state_d   = state_q;
    ar_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    err_d     = err_q;
    cnt_d     = cnt_q;
    grant_end = 1'b0;

    case (state_q)
      ST_INIT: begin
        cnt_d = '0;
        if (init_done) begin
          state_d = ST_ARBIT;
        end
      end

      ST_ARBIT: begin
        cnt_d = '0;
        if (ar_req) begin
          state_d = ST_AREF;
          ar_en_d = 1'b1;
        end else if (wr_req) begin
          state_d = ST_WRITE;
          wr_en_d = 1'b1;
        end else if (rd_req) begin
          state_d = ST_READ;
          rd_en_d = 1'b1;
        end
      end

      ST_AREF, ST_WRITE, ST_READ: begin
        // Only the granted engine's end is honoured.
        case (state_q)
          ST_AREF:  grant_end = ar_end;
          ST_WRITE: grant_end = wr_end;
          default:  grant_end = rd_end;
        endcase

        if (grant_end) begin
          state_d = ST_ARBIT;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_MAX - 10'd1) begin
          // This edge would make the grant TIMEOUT_MAX cycles long.
          state_d = ST_ARBIT;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end

      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_INIT;
      ar_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ar_en_q <= ar_en_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Command bus mux: combinational on the registered state.
  logic [CMD_W-1:0]  bus_cmd;
  logic [BA_W-1:0]   bus_ba;
  logic [ADDR_W-1:0] bus_addr;

  always_comb begin
    bus_cmd  = CMD_NOP;
    bus_ba   = IDLE_BA;
    bus_addr = IDLE_ADDR;
    case (state_q)
      ST_INIT: begin
        bus_cmd  = init_cmd;
        bus_ba   = init_ba;
        bus_addr = init_addr;
      end
      ST_AREF: begin
        bus_cmd  = ar_cmd;
        bus_ba   = ar_ba;
        bus_addr = ar_addr;
      end
      ST_WRITE: begin
        bus_cmd  = wr_cmd;
        bus_ba   = wr_ba;
        bus_addr = wr_addr;
      end
      ST_READ: begin
        bus_cmd  = rd_cmd;
        bus_ba   = rd_ba;
        bus_addr = rd_addr;
      end
      default: begin
        bus_cmd  = CMD_NOP;
        bus_ba   = IDLE_BA;
        bus_addr = IDLE_ADDR;
      end
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = bus_cmd;
  assign sdram_ba    = bus_ba;
  assign sdram_addr  = bus_addr;
  assign sdram_cke   = 1'b1;

  assign sdram_dq_oe = (state_q == ST_WRITE) && wr_sdram_en;
  assign sdram_dq_o  = sdram_dq_oe ? wr_sdram_data : '0;

  assign ar_en   = ar_en_q;
  assign wr_en   = wr_en_q;
  assign rd_en   = rd_en_q;
  assign arb_err = err_q;

endmodule

// File: tb/tb_sdram_arbit.sv
module tb_sdram_arbit;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic [3:0]  init_cmd = 4'h0;
  logic [1:0]  init_ba = 2'h0;
  logic [11:0] init_addr = 12'h0;
  logic        ar_req = 1'b0, ar_end = 1'b0;
  logic [3:0]  ar_cmd = 4'h0;
  logic [1:0]  ar_ba = 2'h0;
  logic [11:0] ar_addr = 12'h0;
  logic        wr_req = 1'b0, wr_end = 1'b0;
  logic [3:0]  wr_cmd = 4'h0;
  logic [1:0]  wr_ba = 2'h0;
  logic [11:0] wr_addr = 12'h0;
  logic        wr_sdram_en = 1'b0;
  logic [15:0] wr_sdram_data = 16'h0;
  logic        rd_req = 1'b0, rd_end = 1'b0;
  logic [3:0]  rd_cmd = 4'h0;
  logic [1:0]  rd_ba = 2'h0;
  logic [11:0] rd_addr = 12'h0;

  logic        ar_en, wr_en, rd_en, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [11:0] sdram_addr;
  logic [15:0] sdram_dq_o;
  logic        sdram_dq_oe, arb_err;

  sdram_arbit dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .init_done(init_done), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .ar_req(ar_req), .ar_end(ar_end), .ar_cmd(ar_cmd), .ar_ba(ar_ba), .ar_addr(ar_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .ar_en(ar_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_o(sdram_dq_o), .sdram_dq_oe(sdram_dq_oe), .arb_err(arb_err)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the bus, whether this is the grant's first
  // cycle, how many cycles the grant has lasted, and the sticky error.
  localparam int O_INIT = 0, O_IDLE = 1, O_AR = 2, O_WR = 3, O_RD = 4;
  localparam int GRANT_LIMIT = 1000;
  int m_owner   = O_INIT;
  bit m_first   = 1'b0;
  int m_elapsed = 0;
  bit m_err     = 1'b0;

  wire [39:0] obs = {ar_en, wr_en, rd_en, sdram_cke,
                     sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
                     sdram_ba, sdram_addr, sdram_dq_o, sdram_dq_oe, arb_err};

  function automatic logic [39:0] expected();
    logic [3:0]  c;
    logic [1:0]  b;
    logic [11:0] a;
    logic        oe;
    logic [15:0] d;
    case (m_owner)
      O_INIT:  begin c = init_cmd; b = init_ba; a = init_addr; end
      O_AR:    begin c = ar_cmd;   b = ar_ba;   a = ar_addr;   end
      O_WR:    begin c = wr_cmd;   b = wr_ba;   a = wr_addr;   end
      O_RD:    begin c = rd_cmd;   b = rd_ba;   a = rd_addr;   end
      default: begin c = 4'b0111;  b = 2'b11;   a = 12'hFFF;   end
    endcase
    oe = (m_owner == O_WR) && wr_sdram_en;
    d  = oe ? wr_sdram_data : 16'h0000;
    return {(m_owner == O_AR) && m_first, (m_owner == O_WR) && m_first,
            (m_owner == O_RD) && m_first, 1'b1, c, b, a, d, oe, m_err};
  endfunction

  task automatic model_reset();
    m_owner = O_INIT; m_first = 1'b0; m_elapsed = 0; m_err = 1'b0;
  endtask

  // Advance the model over one rising edge using the inputs present at it.
  task automatic model_edge();
    bit ended;
    if (!sys_rst_n) begin
      model_reset();
    end else if (m_owner == O_INIT) begin
      if (init_done) m_owner = O_IDLE;
    end else if (m_owner == O_IDLE) begin
      m_elapsed = 0;
      if (ar_req)      begin m_owner = O_AR; m_first = 1'b1; end
      else if (wr_req) begin m_owner = O_WR; m_first = 1'b1; end
      else if (rd_req) begin m_owner = O_RD; m_first = 1'b1; end
    end else begin
      m_first = 1'b0;
      m_elapsed++;
      ended = (m_owner == O_AR && ar_end) || (m_owner == O_WR && wr_end) ||
              (m_owner == O_RD && rd_end);
      if (ended) begin
        m_owner = O_IDLE;
      end else if (m_elapsed == GRANT_LIMIT) begin
        m_owner = O_IDLE;
        m_err   = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [39:0] exp_v;
    exp_v = expected();
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input string tag);
    @(posedge sys_clk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic rnd_bus();
    init_cmd = 4'($urandom); init_ba = 2'($urandom); init_addr = 12'($urandom);
    ar_cmd = 4'($urandom); ar_ba = 2'($urandom); ar_addr = 12'($urandom);
    wr_cmd = 4'($urandom); wr_ba = 2'($urandom); wr_addr = 12'($urandom);
    rd_cmd = 4'($urandom); rd_ba = 2'($urandom); rd_addr = 12'($urandom);
    wr_sdram_en = 1'($urandom); wr_sdram_data = 16'($urandom);
  endtask

  task automatic async_reset(input string tag);
    #2;
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    check(tag);
  endtask

  initial begin
    // ---------------- reset state ----------------
    rnd_bus();
    #1;
    check("reset_state");
    step("in_reset");
    step("in_reset");
    sys_rst_n = 1'b1;

    // ---------------- bring-up ----------------
    $display("[TB] phase bring-up");
    for (int i = 0; i < 20; i++) begin
      rnd_bus();
      ar_req = 1'b1;  // must be ignored until init completes
      step("init_bus");
    end
    ar_req = 1'b0;
    init_done = 1'b1;
    step("init_to_arbit");
    init_done = 1'b0;
    step("arbit_idle");
    init_done = 1'b1;  // ignored outside INIT
    step("init_done_ignored");
    init_done = 1'b0;

    // ---------------- refresh grant ----------------
    $display("[TB] phase refresh");
    ar_req = 1'b1; ar_cmd = 4'b0010;
    step("ar_grant_first");
    ar_req = 1'b0; ar_cmd = 4'b0001;
    wr_end = 1'b1; rd_end = 1'b1;  // non-granted ends are ignored
    step("ar_grant_second");
    wr_end = 1'b0; rd_end = 1'b0;
    ar_end = 1'b1;
    step("ar_end");
    ar_end = 1'b0;
    step("ar_after_end");

    // ---------------- priority ----------------
    $display("[TB] phase priority");
    ar_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    step("prio_aref");
    ar_req = 1'b0; ar_end = 1'b1;
    step("prio_aref_end");
    ar_end = 1'b0;
    step("prio_write");
    wr_req = 1'b0;
    wr_sdram_en = 1'b1; wr_sdram_data = 16'hA5A5;
    step("write_data_on");
    wr_sdram_en = 1'b0;
    step("write_data_off");
    wr_end = 1'b1;
    step("prio_write_end");
    wr_end = 1'b0;
    step("prio_read");
    rd_req = 1'b0; rd_end = 1'b1;
    step("prio_read_end");
    rd_end = 1'b0;
    step("prio_idle");

    // ---------------- timeout ----------------
    $display("[TB] phase timeout");
    rd_req = 1'b1;
    step("to_grant");
    rd_req = 1'b0;
    for (int i = 0; i < GRANT_LIMIT + 3; i++) begin
      rnd_bus();
      wr_req = (i > 900);  // pending request served once the grant is freed
      step("to_hold");
      if (wr_en) wr_req = 1'b0;
    end
    wr_req = 1'b0;
    tests++;
    assert (arb_err === 1'b1) else begin
      fails++;
      $error("FAIL timeout_err_flag: observed %b expected 1", arb_err);
    end
    wr_end = 1'b1;
    step("to_after");
    wr_end = 1'b0;
    step("err_sticky");

    // ---------------- mid-grant reset ----------------
    $display("[TB] phase mid-grant reset");
    wr_req = 1'b1;
    step("mg_write");
    wr_req = 1'b0; wr_sdram_en = 1'b1; wr_sdram_data = 16'h5A5A;
    step("mg_write_hold");
    async_reset("mg_reset_now");
    step("mg_in_reset");
    sys_rst_n = 1'b1;
    step("mg_init_again");
    init_done = 1'b1;
    step("mg_reinit");
    init_done = 1'b0;

    // ---------------- randomized traffic ----------------
    $display("[TB] phase random");
    begin
      bit want_ar = 0, want_wr = 0, want_rd = 0;
      for (int i = 0; i < 3000; i++) begin
        rnd_bus();
        if (!want_ar) want_ar = ($urandom_range(0, 7) == 0);
        if (!want_wr) want_wr = ($urandom_range(0, 3) == 0);
        if (!want_rd) want_rd = ($urandom_range(0, 3) == 0);
        ar_req = want_ar; wr_req = want_wr; rd_req = want_rd;
        ar_end = (m_owner == O_AR && !m_first) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
        wr_end = (m_owner == O_WR && !m_first) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
        rd_end = (m_owner == O_RD && !m_first) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
        init_done = ($urandom_range(0, 4) == 0);
        step("rand");
        if (m_first && m_owner == O_AR) want_ar = 0;
        if (m_first && m_owner == O_WR) want_wr = 0;
        if (m_first && m_owner == O_RD) want_rd = 0;
        if ($urandom_range(0, 499) == 0) begin
          async_reset("rand_reset");
          step("rand_in_reset");
          sys_rst_n = 1'b1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
